// File: rtl/ahb_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_arbiter
//
// Decides which AHB master owns the shared address/control bus. It produces
// a one-hot grant, the registered owner ID used by the address/data muxes,
// and the locked-transfer indication for the current address phase.
//
// Ports:
//   hclk       in   AHB clock
//   hresetn    in   asynchronous active-low reset
//   hbusreq    in   [NUM_MASTERS-1:0] bus request, one bit per master
//   hlock      in   [NUM_MASTERS-1:0] locked-transfer request per master
//   htrans     in   [1:0] transfer type of the current address phase
//   hready     in   bus-wide transfer-complete
//   hgrant     out  [NUM_MASTERS-1:0] one-hot grant
//   hmaster    out  [MID_W-1:0] owner of the current address phase
//   hmastlock  out  current address phase is locked
//
// Build option:
//   ARB_FIXED_PRIO_EN  when defined, the lowest-index requester always wins
//                      and the round-robin pointer is not built. Hold, lock,
//                      tenure and default-master rules are unchanged.
// ---------------------------------------------------------------------------
module ahb_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int MID_W       = 2,
   parameter int DEF_MASTER  = 0,
   parameter int MAX_HOLD    = 16
) (
   input  logic                   hclk,
   input  logic                   hresetn,
   input  logic [NUM_MASTERS-1:0] hbusreq,
   input  logic [NUM_MASTERS-1:0] hlock,
   input  logic [1:0]             htrans,
   input  logic                   hready,
   output logic [NUM_MASTERS-1:0] hgrant,
   output logic [MID_W-1:0]       hmaster,
   output logic                   hmastlock
);

   localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEF_MASTER;
   localparam logic [CNT_W-1:0]       CNT_MAX   = CNT_W'(MAX_HOLD);

   // Configuration sanity, caught at elaboration time.
   if (DEF_MASTER < 0 || DEF_MASTER >= NUM_MASTERS) begin : g_bad_def_master
      $error("ahb_arbiter: DEF_MASTER out of range");
   end
   if ((1 << MID_W) < NUM_MASTERS) begin : g_bad_mid_w
      $error("ahb_arbiter: MID_W too narrow for NUM_MASTERS");
   end

   logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
   logic [MID_W-1:0]       hmaster_q, hmaster_d;
   logic                   hmastlock_q, hmastlock_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
`ifndef ARB_FIXED_PRIO_EN
   logic [MID_W-1:0]       ptr_q, ptr_d;
`endif

   logic [MID_W-1:0] grant_idx;
   logic [MID_W-1:0] win_idx;
   logic             win_found;
   logic             lock_hold;
   logic             expired;
   logic             hold;

   // Encode the one-hot grant into the ID that moves into hmaster.
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (hgrant_q[i]) grant_idx = MID_W'(i);
      end
   end

   // A locked tenure holds the bus; a burst (BUSY/SEQ) holds it only until
   // the tenure limit expires with someone else waiting.
   always_comb begin
      lock_hold = hmastlock_q & hlock[hmaster_q];
      expired   = (MAX_HOLD != 0) && (cnt_q == CNT_MAX) && (|(hbusreq & ~hgrant_q));
      hold      = lock_hold | (htrans[0] & ~expired);
   end

   // Winner search. Loops run from lowest to highest priority so the last
   // match written is the highest-priority requester.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
`ifdef ARB_FIXED_PRIO_EN
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (hbusreq[i]) begin
            win_found = 1'b1;
            win_idx   = MID_W'(i);
         end
      end
`else
      // Candidate i steps above the pointer; i = NUM_MASTERS is the pointer
      // itself, so a sole requester that already owns the bus is re-granted.
      for (int i = NUM_MASTERS; i >= 1; i--) begin
         if (hbusreq[(int'(ptr_q) + i) % NUM_MASTERS]) begin
            win_found = 1'b1;
            win_idx   = MID_W'((int'(ptr_q) + i) % NUM_MASTERS);
         end
      end
`endif
   end

   always_comb begin
      hgrant_d    = hgrant_q;
      hmaster_d   = hmaster_q;
      hmastlock_d = hmastlock_q;
      cnt_d       = cnt_q;
`ifndef ARB_FIXED_PRIO_EN
      ptr_d       = ptr_q;
`endif
      if (hready) begin
         hmaster_d   = grant_idx;
         hmastlock_d = hlock[grant_idx];
         if (!hold) begin
            if (win_found) begin
               hgrant_d = NUM_MASTERS'(1) << win_idx;
`ifndef ARB_FIXED_PRIO_EN
               ptr_d    = win_idx;
`endif
            end else begin
               hgrant_d = DEF_GRANT;
            end
         end
         // Tenure counts NONSEQ/SEQ beats of an unchanged grant, saturating.
         if (hgrant_d != hgrant_q) begin
            cnt_d = '0;
         end else if (htrans[1] && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         hgrant_q    <= DEF_GRANT;
         hmaster_q   <= MID_W'(DEF_MASTER);
         hmastlock_q <= 1'b0;
         cnt_q       <= '0;
`ifndef ARB_FIXED_PRIO_EN
         ptr_q       <= MID_W'(DEF_MASTER);
`endif
      end else begin
         hgrant_q    <= hgrant_d;
         hmaster_q   <= hmaster_d;
         hmastlock_q <= hmastlock_d;
         cnt_q       <= cnt_d;
`ifndef ARB_FIXED_PRIO_EN
         ptr_q       <= ptr_d;
`endif
      end
   end

   assign hgrant    = hgrant_q;
   assign hmaster   = hmaster_q;
   assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_arbiter
//
// Directed bench for ahb_arbiter with default parameters (4 masters,
// DEF_MASTER 0, MAX_HOLD 16). Inputs change 1 ns after a rising edge and
// outputs are sampled at that same point, so every check sees the registers
// updated by the edge just taken.
// ---------------------------------------------------------------------------
module tb_ahb_arbiter;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] SEQ    = 2'b11;

   logic       hclk;
   logic       hresetn;
   logic [3:0] hbusreq;
   logic [3:0] hlock;
   logic [1:0] htrans;
   logic       hready;
   logic [3:0] hgrant;
   logic [1:0] hmaster;
   logic       hmastlock;

   int n_cmp;
   int n_bad;

   ahb_arbiter #(
      .NUM_MASTERS(4),
      .MID_W      (2),
      .DEF_MASTER (0),
      .MAX_HOLD   (16)
   ) dut (
      .hclk     (hclk),
      .hresetn  (hresetn),
      .hbusreq  (hbusreq),
      .hlock    (hlock),
      .htrans   (htrans),
      .hready   (hready),
      .hgrant   (hgrant),
      .hmaster  (hmaster),
      .hmastlock(hmastlock)
   );

   // clock / reset
   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic drive(input logic [3:0] req, input logic [3:0] lck,
                        input logic [1:0] tr, input logic rdy);
      hbusreq = req;
      hlock   = lck;
      htrans  = tr;
      hready  = rdy;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_bus(input string tag, input logic [3:0] g, input logic [1:0] m,
                            input logic l);
      check({tag, ".hgrant"}, {4'h0, hgrant}, {4'h0, g});
      check({tag, ".hmaster"}, {6'h0, hmaster}, {6'h0, m});
      check({tag, ".hmastlock"}, {7'h0, hmastlock}, {7'h0, l});
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      hresetn = 1'b0;
      drive(4'b0000, 4'b0000, IDLE, 1'b1);

      // 1: reset state and idle default master
      tick();
      check_bus("reset", 4'b0001, 2'd0, 1'b0);
      hresetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_bus("idle_default", 4'b0001, 2'd0, 1'b0);
      end

      // 2: round-robin between masters 1 and 3, hmaster one edge behind
      drive(4'b1010, 4'b0000, NONSEQ, 1'b1);
      tick(); check_bus("rr_e1", 4'b0010, 2'd0, 1'b0);
      tick(); check_bus("rr_e2", 4'b1000, 2'd1, 1'b0);
      tick(); check_bus("rr_e3", 4'b0010, 2'd3, 1'b0);
      tick(); check_bus("rr_e4", 4'b1000, 2'd1, 1'b0);

      // 3: master 2 eight-beat burst, master 0 waiting, stalls on beats 3 and 5
      drive(4'b0100, 4'b0000, IDLE, 1'b1);
      tick(); check_bus("burst_grant", 4'b0100, 2'd3, 1'b0);
      drive(4'b0100, 4'b0000, NONSEQ, 1'b1);
      tick(); check_bus("burst_b1", 4'b0100, 2'd2, 1'b0);
      drive(4'b0101, 4'b0000, SEQ, 1'b1);
      tick(); check_bus("burst_b2", 4'b0100, 2'd2, 1'b0);
      hready = 1'b0;
      tick(); check_bus("burst_b3_stall", 4'b0100, 2'd2, 1'b0);
      hready = 1'b1;
      tick(); check_bus("burst_b3", 4'b0100, 2'd2, 1'b0);
      tick(); check_bus("burst_b4", 4'b0100, 2'd2, 1'b0);
      hready = 1'b0;
      tick(); check_bus("burst_b5_stall", 4'b0100, 2'd2, 1'b0);
      hready = 1'b1;
      for (int b = 5; b <= 8; b++) begin
         tick(); check_bus("burst_seq", 4'b0100, 2'd2, 1'b0);
      end
      drive(4'b0001, 4'b0000, IDLE, 1'b1);
      tick(); check_bus("burst_end", 4'b0001, 2'd2, 1'b0);

      // 4a: master 1 endless SEQ, master 3 waiting -> tenure limit pre-empts
      drive(4'b0010, 4'b0000, IDLE, 1'b1);
      tick(); check_bus("ten_grant", 4'b0010, 2'd0, 1'b0);
      drive(4'b0010, 4'b0000, NONSEQ, 1'b1);
      tick(); check_bus("ten_nonseq", 4'b0010, 2'd1, 1'b0);
      drive(4'b1010, 4'b0000, SEQ, 1'b1);
      for (int b = 0; b < 15; b++) begin
         tick(); check_bus("ten_hold", 4'b0010, 2'd1, 1'b0);
      end
      tick(); check_bus("ten_expire", 4'b1000, 2'd1, 1'b0);

      // 4b: same with hlock[1] -> grant never moves, limit ignored
      drive(4'b0010, 4'b0010, IDLE, 1'b1);
      tick(); check_bus("lk_grant", 4'b0010, 2'd3, 1'b0);
      drive(4'b0010, 4'b0010, NONSEQ, 1'b1);
      tick(); check_bus("lk_nonseq", 4'b0010, 2'd1, 1'b1);
      drive(4'b1010, 4'b0010, SEQ, 1'b1);
      for (int b = 0; b < 20; b++) begin
         tick(); check_bus("lk_hold", 4'b0010, 2'd1, 1'b1);
      end
      // lock release with a pending request: arbitration runs on this edge
      drive(4'b1010, 4'b0000, IDLE, 1'b1);
      tick(); check_bus("lk_release", 4'b1000, 2'd1, 1'b0);

      // 5: locked read-write pair by master 2 with everyone requesting
      drive(4'b0100, 4'b0100, IDLE, 1'b1);
      tick(); check_bus("pair_grant", 4'b0100, 2'd3, 1'b0);
      tick(); check_bus("pair_own", 4'b0100, 2'd2, 1'b1);
      drive(4'b1111, 4'b0100, NONSEQ, 1'b1);
      tick(); check_bus("pair_wr", 4'b0100, 2'd2, 1'b1);
      tick(); check_bus("pair_rd", 4'b0100, 2'd2, 1'b1);
      drive(4'b1111, 4'b0000, IDLE, 1'b1);
      tick(); check_bus("pair_unlock", 4'b1000, 2'd2, 1'b0);

      // 6: masters 1..3 requesting continuously
      drive(4'b1110, 4'b0000, NONSEQ, 1'b1);
`ifdef ARB_FIXED_PRIO_EN
      tick(); check_bus("prio_e1", 4'b0010, 2'd3, 1'b0);
      tick(); check_bus("prio_e2", 4'b0010, 2'd1, 1'b0);
      tick(); check_bus("prio_e3", 4'b0010, 2'd1, 1'b0);
      tick(); check_bus("prio_e4", 4'b0010, 2'd1, 1'b0);
`else
      tick(); check_bus("rr3_e1", 4'b0010, 2'd3, 1'b0);
      tick(); check_bus("rr3_e2", 4'b0100, 2'd1, 1'b0);
      tick(); check_bus("rr3_e3", 4'b1000, 2'd2, 1'b0);
      tick(); check_bus("rr3_e4", 4'b0010, 2'd3, 1'b0);
`endif
      drive(4'b1000, 4'b0000, NONSEQ, 1'b1);
      tick(); check_bus("only3", 4'b1000, 2'd1, 1'b0);

      // asynchronous reset in the middle of a transfer
      drive(4'b0010, 4'b0000, NONSEQ, 1'b1);
      hresetn = 1'b0;
      #1;
      check_bus("async_rst", 4'b0001, 2'd0, 1'b0);
      tick();
      hresetn = 1'b1;
      hready  = 1'b0;
      tick(); check_bus("post_rst_stall", 4'b0001, 2'd0, 1'b0);
      hready = 1'b1;
      tick(); check_bus("post_rst_arb", 4'b0010, 2'd0, 1'b0);

      // requests dropped on the evaluating edge -> default master
      drive(4'b0000, 4'b0000, IDLE, 1'b1);
      tick(); check_bus("drop_default", 4'b0001, 2'd1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
